// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// -----------------------------------------------------------------------------
// Shares one sequential signed multiplier core between two requesters.
// A round-robin grant picks a requester in IDLE. Its operands are latched and
// presented to the core, and one start pulse is issued. The block then waits
// for the core's ready pulse under a watchdog. The product, or a timeout
// response, is held with the winner's ID until the consumer accepts it.
//
// Ports
//   clock_i, reset_i          rising-edge clock, synchronous active-high reset
//   reqN_i, aN_i, bN_i        requester N request with its operands (N = 0, 1)
//   ackN_o                    one-cycle pulse: requester N granted, operands taken
//   mul_start_o               one-cycle start pulse to the multiplier core
//   mul_multiplicand_o        latched operand, held until the next grant
//   mul_multiplier_o          latched operand, held until the next grant
//   mul_ready_i               core completion pulse (honoured only while waiting)
//   mul_result_i, mul_negative_i, mul_overflow_i
//                             core product and flags, valid with mul_ready_i
//   rsp_valid_o / rsp_ready_i response handshake
//   rsp_id_o                  requester that owns the response
//   rsp_result_o, rsp_negative_o, rsp_overflow_o
//                             captured product and flags (all zero on timeout)
//   rsp_timeout_o             core did not answer within TIMEOUT wait cycles
//   busy_o                    high whenever the controller is not idle
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int LENGTH  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  req0_i,
  input  logic [LENGTH-1:0]     a0_i,
  input  logic [LENGTH-1:0]     b0_i,
  output logic                  ack0_o,
  input  logic                  req1_i,
  input  logic [LENGTH-1:0]     a1_i,
  input  logic [LENGTH-1:0]     b1_i,
  output logic                  ack1_o,
  output logic                  mul_start_o,
  output logic [LENGTH-1:0]     mul_multiplicand_o,
  output logic [LENGTH-1:0]     mul_multiplier_o,
  input  logic                  mul_ready_i,
  input  logic [2*LENGTH-1:0]   mul_result_i,
  input  logic                  mul_negative_i,
  input  logic                  mul_overflow_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [2*LENGTH-1:0]   rsp_result_o,
  output logic                  rsp_negative_o,
  output logic                  rsp_overflow_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o
);

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  rr_ptr_q;
  logic                  gnt_id_q;
  logic [CW-1:0]         cnt_q;
  logic [LENGTH-1:0]     mcand_q;
  logic [LENGTH-1:0]     mplier_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic                  start_q;
  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [2*LENGTH-1:0]   rsp_result_q;
  logic                  rsp_negative_q;
  logic                  rsp_overflow_q;
  logic                  rsp_timeout_q;
  logic                  busy_q;

  // Winner selection: a lone requester wins outright; on contention the
  // round-robin pointer decides.
  logic any_req_d;
  logic gnt_d;

  always_comb begin
    any_req_d = req0_i | req1_i;
    gnt_d     = (req0_i && req1_i) ? rr_ptr_q : req1_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= 1'b0;
      gnt_id_q       <= 1'b0;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      start_q        <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_negative_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // Grant and start are single-cycle pulses.
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      start_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            gnt_id_q <= gnt_d;
            mcand_q  <= gnt_d ? a1_i : a0_i;
            mplier_q <= gnt_d ? b1_i : b0_i;
            ack0_q   <= ~gnt_d;
            ack1_q   <= gnt_d;
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          // Ready takes priority over the watchdog on the final wait cycle.
          if (mul_ready_i) begin
            rsp_result_q   <= mul_result_i;
            rsp_negative_q <= mul_negative_i;
            rsp_overflow_q <= mul_overflow_i;
            rsp_timeout_q  <= 1'b0;
            rsp_id_q       <= gnt_id_q;
            rsp_valid_q    <= 1'b1;
            state_q        <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            rsp_result_q   <= '0;
            rsp_negative_q <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_timeout_q  <= 1'b1;
            rsp_id_q       <= gnt_id_q;
            rsp_valid_q    <= 1'b1;
            state_q        <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          // Response fields stay put after acceptance; only valid drops.
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= ~gnt_id_q;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0_o             = ack0_q;
  assign ack1_o             = ack1_q;
  assign mul_start_o        = start_q;
  assign mul_multiplicand_o = mcand_q;
  assign mul_multiplier_o   = mplier_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_id_o           = rsp_id_q;
  assign rsp_result_o       = rsp_result_q;
  assign rsp_negative_o     = rsp_negative_q;
  assign rsp_overflow_o     = rsp_overflow_q;
  assign rsp_timeout_o      = rsp_timeout_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
// Bench for mult_share_arbiter. The bench plays both requesters, the
// multiplier core and the response consumer. A transaction-level model
// (pending requests, round-robin pointer, expected response per job) produces
// every expected value.
module tb_mult_share_arbiter;

  localparam int LENGTH  = 5;
  localparam int TIMEOUT = 16;
  localparam int PW      = 2 * LENGTH;
  localparam int OW      = 3 + 2 * LENGTH + 2 + PW + 4;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              req0_i = 1'b0, req1_i = 1'b0;
  logic [LENGTH-1:0] a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
  logic              ack0_o, ack1_o, mul_start_o;
  logic [LENGTH-1:0] mul_multiplicand_o, mul_multiplier_o;
  logic              mul_ready_i = 1'b0;
  logic [PW-1:0]     mul_result_i = '0;
  logic              mul_negative_i = 1'b0, mul_overflow_i = 1'b0;
  logic              rsp_valid_o, rsp_ready_i = 1'b0, rsp_id_o;
  logic [PW-1:0]     rsp_result_o;
  logic              rsp_negative_o, rsp_overflow_o, rsp_timeout_o, busy_o;

  int   n_vec = 0;
  int   n_err = 0;
  logic rr_m  = 1'b0;   // model of the round-robin pointer

  always #5 clock_i = ~clock_i;

  mult_share_arbiter #(.LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req0_i(req0_i), .a0_i(a0_i), .b0_i(b0_i), .ack0_o(ack0_o),
    .req1_i(req1_i), .a1_i(a1_i), .b1_i(b1_i), .ack1_o(ack1_o),
    .mul_start_o(mul_start_o),
    .mul_multiplicand_o(mul_multiplicand_o), .mul_multiplier_o(mul_multiplier_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
    .mul_negative_i(mul_negative_i), .mul_overflow_i(mul_overflow_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_result_o(rsp_result_o), .rsp_negative_o(rsp_negative_o),
    .rsp_overflow_o(rsp_overflow_o), .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [OW-1:0] all_outs();
    return {ack0_o, ack1_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o,
            rsp_valid_o, rsp_id_o, rsp_result_o, rsp_negative_o,
            rsp_overflow_o, rsp_timeout_o, busy_o};
  endfunction

  function automatic logic [PW-1:0] sprod(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b);
    logic signed [PW-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Ticks until an ack appears; returns the number of edges, -1 if none.
  task automatic wait_grant(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack0_o || ack1_o) begin
        cyc = i + 1;
        break;
      end
    end
  endtask

  // Called during WAIT cycle 0. Acts as the core: pulses ready in WAIT cycle d
  // (never if d >= TIMEOUT) and returns how many edges after WAIT entry
  // rsp_valid appeared (-1 if never).
  task automatic run_wait(input int d, input logic [PW-1:0] r, input logic n,
                          input logic o, output int edges);
    edges = -1;
    for (int c = 0; c < 40; c++) begin
      if (c == d) begin
        mul_ready_i = 1'b1; mul_result_i = r; mul_negative_i = n; mul_overflow_i = o;
      end else begin
        mul_ready_i = 1'b0; mul_result_i = PW'($urandom);
        mul_negative_i = 1'($urandom); mul_overflow_i = 1'($urandom);
      end
      tick();
      mul_ready_i = 1'b0;
      if (rsp_valid_o) begin
        edges = c + 1;
        break;
      end
    end
  endtask

  task automatic accept();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(); tick();
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    reset_i = 1'b0;
    rr_m = 1'b0;
    tick();
    n_vec++;
    if ({busy_o, rsp_valid_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle: busy/valid got %b expected 00", {busy_o, rsp_valid_o});
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single();
    int cyc, edges;
    req0_i = 1'b1; a0_i = 5'd3; b0_i = 5'd7;
    wait_grant(cyc);
    n_vec++;
    if (cyc !== 1) begin n_err++; $display("FAIL single_ack_latency: got %0d expected 1", cyc); end
    n_vec++;
    if ({ack0_o, ack1_o, mul_start_o} !== 3'b101) begin
      n_err++; $display("FAIL single_ack_start: got %b expected 101", {ack0_o, ack1_o, mul_start_o});
    end
    n_vec++;
    if ({mul_multiplicand_o, mul_multiplier_o} !== {5'd3, 5'd7}) begin
      n_err++; $display("FAIL single_operands: got %0d,%0d expected 3,7", mul_multiplicand_o, mul_multiplier_o);
    end
    req0_i = 1'b0;
    tick();
    run_wait(2, 10'd21, 1'b0, 1'b0, edges);
    n_vec++;
    if (edges !== 3) begin n_err++; $display("FAIL single_latency: got %0d expected 3", edges); end
    n_vec++;
    if ({rsp_id_o, rsp_result_o, rsp_timeout_o} !== {1'b0, 10'd21, 1'b0}) begin
      n_err++; $display("FAIL single_rsp: got id=%0d res=%0d to=%0d expected 0,21,0", rsp_id_o, rsp_result_o, rsp_timeout_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({rsp_valid_o, rsp_result_o, rsp_timeout_o} !== {1'b1, 10'd21, 1'b0}) begin
        n_err++; $display("FAIL single_hold: got v=%0d res=%0d expected 1,21", rsp_valid_o, rsp_result_o);
      end
    end
    accept();
    n_vec++;
    if ({rsp_valid_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL single_release: valid/busy got %b expected 00", {rsp_valid_o, busy_o});
    end
    rr_m = 1'b1;
    $display("single: id=0 3*7 result=%0d", rsp_result_o);
  endtask

  task automatic test_contention();
    int cyc, edges, d;
    logic exp;
    logic [PW-1:0] p;
    reset_i = 1'b1; tick(); reset_i = 1'b0; rr_m = 1'b0;
    a0_i = LENGTH'($urandom); b0_i = LENGTH'($urandom);
    a1_i = LENGTH'($urandom); b1_i = LENGTH'($urandom);
    req0_i = 1'b1; req1_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp = rr_m;
      p = exp ? sprod(a1_i, b1_i) : sprod(a0_i, b0_i);
      wait_grant(cyc);
      n_vec++;
      if ({ack0_o, ack1_o} !== (exp ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL contention_grant%0d: ack0/ack1 got %b expected id %0d", j, {ack0_o, ack1_o}, exp);
      end
      n_vec++;
      if ({mul_multiplicand_o, mul_multiplier_o} !== (exp ? {a1_i, b1_i} : {a0_i, b0_i})) begin
        n_err++; $display("FAIL contention_operands%0d: got %h expected id %0d operands", j, {mul_multiplicand_o, mul_multiplier_o}, exp);
      end
      // Requester keeps asking, with fresh operands for its next job.
      if (exp) begin a1_i = LENGTH'($urandom); b1_i = LENGTH'($urandom); end
      else     begin a0_i = LENGTH'($urandom); b0_i = LENGTH'($urandom); end
      tick();
      n_vec++;
      if ({ack0_o, ack1_o, mul_start_o} !== 3'b000) begin
        n_err++; $display("FAIL contention_pulse%0d: ack/start got %b expected 000", j, {ack0_o, ack1_o, mul_start_o});
      end
      d = $urandom_range(0, 4);
      run_wait(d, p, p[PW-1], 1'b0, edges);
      n_vec++;
      if ({rsp_id_o, rsp_result_o, rsp_timeout_o} !== {exp, p, 1'b0}) begin
        n_err++; $display("FAIL contention_rsp%0d: got id=%0d res=%h expected id=%0d res=%h", j, rsp_id_o, rsp_result_o, exp, p);
      end
      accept();
      rr_m = ~exp;
      $display("contention job %0d: granted id=%0d result=%h", j, exp, p);
    end
    req0_i = 1'b0; req1_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc, edges;
    logic [PW-1:0] p;
    req0_i = 1'b1; a0_i = LENGTH'($urandom); b0_i = LENGTH'($urandom);
    p = sprod(a0_i, b0_i);
    wait_grant(cyc);
    n_vec++;
    if ({ack0_o, ack1_o} !== 2'b10) begin
      n_err++; $display("FAIL bp_first_grant: got %b expected 10", {ack0_o, ack1_o});
    end
    req0_i = 1'b0;
    req1_i = 1'b1; a1_i = LENGTH'($urandom); b1_i = LENGTH'($urandom);
    tick();
    run_wait(0, p, 1'b1, 1'b1, edges);
    n_vec++;
    if (edges !== 1) begin n_err++; $display("FAIL bp_latency: got %0d expected 1", edges); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_negative_o, rsp_overflow_o, rsp_timeout_o, busy_o, ack0_o, ack1_o}
          !== {1'b1, 1'b0, p, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL bp_hold%0d: v=%0d id=%0d res=%h busy=%0d ack1=%0d expected 1,0,%h,1,0", i,
                          rsp_valid_o, rsp_id_o, rsp_result_o, busy_o, ack1_o, p);
      end
    end
    accept();
    n_vec++;
    if ({rsp_valid_o, busy_o, ack1_o} !== 3'b000) begin
      n_err++; $display("FAIL bp_release: valid/busy/ack1 got %b expected 000", {rsp_valid_o, busy_o, ack1_o});
    end
    rr_m = 1'b1;
    tick();
    n_vec++;
    if ({ack0_o, ack1_o, mul_multiplicand_o, mul_multiplier_o} !== {1'b0, 1'b1, a1_i, b1_i}) begin
      n_err++; $display("FAIL bp_second_grant: ack=%b ops=%h expected 01 %h", {ack0_o, ack1_o},
                        {mul_multiplicand_o, mul_multiplier_o}, {a1_i, b1_i});
    end
    req1_i = 1'b0;
    tick();
    run_wait(1, PW'(0), 1'b0, 1'b0, edges);
    accept();
    rr_m = 1'b0;
    $display("backpressure: held 5 cycles, then id=1 granted");
  endtask

  task automatic test_timeout();
    int cyc, edges;
    logic [PW-1:0] p;
    req0_i = 1'b1; a0_i = LENGTH'($urandom); b0_i = LENGTH'($urandom);
    wait_grant(cyc);
    req0_i = 1'b0;
    tick();
    run_wait(1000, PW'(0), 1'b0, 1'b0, edges);
    n_vec++;
    if (edges !== TIMEOUT) begin n_err++; $display("FAIL timeout_latency: got %0d expected %0d", edges, TIMEOUT); end
    n_vec++;
    if ({rsp_id_o, rsp_result_o, rsp_negative_o, rsp_overflow_o, rsp_timeout_o} !== {1'b0, PW'(0), 3'b001}) begin
      n_err++; $display("FAIL timeout_rsp: res=%h neg=%0d ovf=%0d to=%0d expected 0,0,0,1",
                        rsp_result_o, rsp_negative_o, rsp_overflow_o, rsp_timeout_o);
    end
    accept();
    rr_m = 1'b1;
    req1_i = 1'b1; a1_i = LENGTH'($urandom); b1_i = LENGTH'($urandom);
    p = sprod(a1_i, b1_i);
    wait_grant(cyc);
    req1_i = 1'b0;
    tick();
    run_wait(TIMEOUT - 1, p, p[PW-1], 1'b0, edges);
    n_vec++;
    if (edges !== TIMEOUT) begin n_err++; $display("FAIL late_ready_latency: got %0d expected %0d", edges, TIMEOUT); end
    n_vec++;
    if ({rsp_id_o, rsp_result_o, rsp_timeout_o} !== {1'b1, p, 1'b0}) begin
      n_err++; $display("FAIL late_ready_rsp: id=%0d res=%h to=%0d expected 1,%h,0", rsp_id_o, rsp_result_o, rsp_timeout_o, p);
    end
    accept();
    rr_m = 1'b0;
    $display("timeout: abort at %0d cycles, last-cycle ready honoured", TIMEOUT);
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    req0_i = 1'b1; a0_i = LENGTH'($urandom); b0_i = LENGTH'($urandom);
    wait_grant(cyc);
    req0_i = 1'b0;
    tick(); tick(); tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    rr_m = 1'b0;
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
    end
    mul_ready_i = 1'b1; mul_result_i = PW'($urandom); mul_negative_i = 1'b1;
    tick();
    mul_ready_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_o || busy_o) seen++;
      tick();
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL stray_ready: active cycles got %0d expected 0", seen); end
    $display("reset_mid: in-flight job discarded");
  endtask

  task automatic test_signed();
    int cyc, edges;
    req1_i = 1'b1; a1_i = 5'h1B; b1_i = 5'd6;   // -5 * 6 = -30
    wait_grant(cyc);
    req1_i = 1'b0;
    tick();
    run_wait(3, 10'h3E2, 1'b1, 1'b1, edges);
    n_vec++;
    if ({rsp_id_o, rsp_result_o, rsp_negative_o, rsp_overflow_o, rsp_timeout_o} !== {1'b1, 10'h3E2, 3'b110}) begin
      n_err++; $display("FAIL signed_rsp: id=%0d res=%h neg=%0d ovf=%0d to=%0d expected 1,3e2,1,1,0",
                        rsp_id_o, rsp_result_o, rsp_negative_o, rsp_overflow_o, rsp_timeout_o);
    end
    accept();
    rr_m = 1'b0;
    $display("signed: result=%h neg=%0d ovf=%0d", rsp_result_o, rsp_negative_o, rsp_overflow_o);
  endtask

  task automatic test_random();
    int cyc, edges, d, bp, exp_edges;
    logic pend0, pend1, exp, o;
    logic [PW-1:0] p, exp_res;
    pend0 = 1'b0; pend1 = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1'b1; a0_i = LENGTH'($urandom); b0_i = LENGTH'($urandom);
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1'b1; a1_i = LENGTH'($urandom); b1_i = LENGTH'($urandom);
      end
      if (!pend0 && !pend1) begin
        pend0 = 1'b1; a0_i = LENGTH'($urandom); b0_i = LENGTH'($urandom);
      end
      req0_i = pend0; req1_i = pend1;
      exp = (pend0 && pend1) ? rr_m : pend1;
      wait_grant(cyc);
      n_vec++;
      if ({cyc, ack0_o, ack1_o} !== {32'd1, ~exp, exp}) begin
        n_err++; $display("FAIL rand_grant%0d: cyc=%0d ack=%b expected 1 id=%0d", j, cyc, {ack0_o, ack1_o}, exp);
      end
      n_vec++;
      if ({mul_multiplicand_o, mul_multiplier_o} !== (exp ? {a1_i, b1_i} : {a0_i, b0_i})) begin
        n_err++; $display("FAIL rand_operands%0d: got %h for id %0d", j, {mul_multiplicand_o, mul_multiplier_o}, exp);
      end
      p = exp ? sprod(a1_i, b1_i) : sprod(a0_i, b0_i);
      if (exp) begin pend1 = 1'b0; req1_i = 1'b0; end
      else     begin pend0 = 1'b0; req0_i = 1'b0; end
      tick();
      d = $urandom_range(0, 20);
      o = 1'($urandom);
      run_wait(d, p, p[PW-1], o, edges);
      exp_edges = (d < TIMEOUT) ? d + 1 : TIMEOUT;
      exp_res   = (d < TIMEOUT) ? p : PW'(0);
      n_vec++;
      if (edges !== exp_edges) begin
        n_err++; $display("FAIL rand_latency%0d: got %0d expected %0d", j, edges, exp_edges);
      end
      n_vec++;
      if ({rsp_id_o, rsp_result_o, rsp_negative_o, rsp_overflow_o, rsp_timeout_o} !==
          ((d < TIMEOUT) ? {exp, exp_res, p[PW-1], o, 1'b0} : {exp, exp_res, 3'b001})) begin
        n_err++; $display("FAIL rand_rsp%0d: id=%0d res=%h neg=%0d ovf=%0d to=%0d expected id=%0d res=%h timeout=%0d",
                          j, rsp_id_o, rsp_result_o, rsp_negative_o, rsp_overflow_o, rsp_timeout_o,
                          exp, exp_res, (d >= TIMEOUT));
      end
      bp = $urandom_range(0, 3);
      for (int i = 0; i < bp; i++) tick();
      n_vec++;
      if ({rsp_valid_o, ack0_o, ack1_o} !== 3'b100) begin
        n_err++; $display("FAIL rand_hold%0d: valid/ack got %b expected 100", j, {rsp_valid_o, ack0_o, ack1_o});
      end
      accept();
      rr_m = ~exp;
      $display("rand job %0d: id=%0d delay=%0d result=%h timeout=%0d", j, exp, d, exp_res, (d >= TIMEOUT));
    end
    req0_i = 1'b0; req1_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_signed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Controller that shares one sequential signed multiplier core between two requesters. It arbitrates round-robin, latches the winner's operands, and pulses start into the core. It waits for the core's ready pulse under a timeout watchdog, then holds the product with the winner's ID until the consumer accepts it. It sits between the operand-capture registers and the multiplier FSM, ahead of the result register and BCD display path.

Parameters:
LENGTH, 5, operand width in bits; product is 2*LENGTH bits
TIMEOUT, 16, max WAIT cycles allowed for mul_ready before abort (must be >= 2)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising edge
req0  in  1  requester 0 request; held with operands until ack0
a0  in  LENGTH  requester 0 multiplicand
b0  in  LENGTH  requester 0 multiplier
ack0  out  1  one-cycle pulse: requester 0 granted, operands captured
req1, a1, b1, ack1  same as requester 0, for requester 1
mul_start  out  1  one-cycle start pulse to the multiplier core
mul_multiplicand  out  LENGTH  latched operand; stable from ISSUE to end of WAIT
mul_multiplier  out  LENGTH  latched operand; stable from ISSUE to end of WAIT
mul_ready  in  1  core completion pulse
mul_result  in  2*LENGTH  core product, valid with mul_ready
mul_negative  in  1  core sign flag, valid with mul_ready
mul_overflow  in  1  core overflow flag, valid with mul_ready
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_result  out  2*LENGTH  product; 0 on timeout
rsp_negative  out  1  captured sign flag; 0 on timeout
rsp_overflow  out  1  captured overflow flag; 0 on timeout
rsp_timeout  out  1  1 = core did not answer within TIMEOUT
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, wait counter=0. All outputs are 0, including operand outputs and response fields.
- Reset in any state returns the block to IDLE on that edge and discards any in-flight job. A mul_ready arriving after reset is ignored.
- States:
  - IDLE: ack*, mul_start and rsp_valid are low.
    - Any req: grant per round-robin. Single requester wins outright. Both requesting: requester rr_ptr wins.
    - On that edge: latch the winner's a/b into the operand registers, latch gnt_id, go to ISSUE.
  - ISSUE (exactly 1 cycle): ack<gnt_id>=1 and mul_start=1. Next state is WAIT with counter=0.
  - WAIT:
    - mul_ready=1: capture mul_result, mul_negative and mul_overflow; set rsp_timeout=0; go to DONE.
    - Else if counter==TIMEOUT-1: set rsp_result=0, flags=0, rsp_timeout=1; go to DONE.
    - Else: counter+1.
    - If mul_ready coincides with the timeout cycle, ready wins (no timeout).
  - DONE: rsp_valid=1, rsp_id=gnt_id, response fields held stable.
    - On rsp_valid&&rsp_ready: go to IDLE and set rr_ptr = ~gnt_id.
    - rsp_valid drops the cycle after acceptance.
- Latency: req sampled in IDLE → ack/mul_start one cycle later. Core ready in WAIT cycle k → rsp_valid at WAIT entry + k + 1. Minimum req-to-rsp_valid is 3 cycles (ready in first WAIT cycle).
- mul_ready outside WAIT is ignored.
- Requests arriving in non-IDLE states are not acked. A req held through a job is served on return to IDLE; no request is lost while held.
- Fairness: with both reqs continuously asserted, grants alternate 0,1,0,1…
- Operand outputs keep their last latched values after DONE until the next grant.
- No arithmetic is performed in this block; widths pass through unchanged.

Test Plan:
- Single request: req0, a0=5'd3, b0=5'd7; core pulses ready with 10'd21 two cycles into WAIT → ack0 one cycle after req, mul_start coincident with it, then rsp_valid with rsp_id=0, rsp_result=21, rsp_timeout=0; held until rsp_ready.
- Contention: req0 and req1 both held high through four jobs → grant order 0,1,0,1. Each ack is a single-cycle pulse and goes to the correct requester; operands on mul_* match that requester.
- Backpressure: rsp_ready low for 5 cycles in DONE → rsp_valid and all response fields stable, busy=1, no ack issued despite a pending req1. Raising rsp_ready → IDLE next cycle, then req1 is granted.
- Timeout: core never responds, TIMEOUT=16 → rsp_valid exactly 16 cycles after WAIT entry with rsp_timeout=1 and rsp_result=0. A mul_ready on the 16th WAIT cycle instead yields rsp_timeout=0 with its product.
- Reset mid-operation: assert reset during WAIT → next edge all outputs 0 and state IDLE. A subsequent stray mul_ready is ignored: no rsp_valid appears.
- Signed pass-through: core returns negative=1, overflow=1, result=10'h3E2 → rsp_negative=1, rsp_overflow=1, rsp_result=10'h3E2.
